// File: rtl/hazard_pkg.sv
// Shared types and constant control vectors for the pipeline hazard controller.
// The load-use detector lives here so other pipeline blocks can reuse it.
package hazard_pkg;

    typedef enum logic [0:0] {
        HZ_RUN      = 1'b0,
        HZ_MEM_WAIT = 1'b1
    } hz_state_t;

    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_DEFAULT = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_flush: 1'b0,
        ex_mem_write: 1'b1, mem_wb_flush: 1'b0
    };

    // Nothing advances; MEM/WB receives a bubble so the stalled access retires once.
    localparam hz_ctrl_t CTRL_FREEZE = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b0, id_ex_flush: 1'b0,
        ex_mem_write: 1'b0, mem_wb_flush: 1'b1
    };

    localparam hz_ctrl_t CTRL_FLUSH = '{
        pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
        id_ex_write: 1'b1, id_ex_flush: 1'b1,
        ex_mem_write: 1'b1, mem_wb_flush: 1'b0
    };

    localparam hz_ctrl_t CTRL_STALL = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
        id_ex_write: 1'b1, id_ex_flush: 1'b1,
        ex_mem_write: 1'b1, mem_wb_flush: 1'b0
    };

    localparam hz_ctrl_t CTRL_RESET = '{
        pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
        id_ex_write: 1'b0, id_ex_flush: 1'b1,
        ex_mem_write: 1'b0, mem_wb_flush: 1'b1
    };

    function automatic logic load_use_hit(
        input logic       id_ex_valid,
        input logic       id_ex_mem_read,
        input logic [4:0] id_ex_rd,
        input logic [4:0] id_rs1,
        input logic [4:0] id_rs2,
        input logic       id_use_rs1,
        input logic       id_use_rs2
    );
        logic rs1_match;
        logic rs2_match;
        rs1_match = id_use_rs1 && (id_rs1 == id_ex_rd);
        rs2_match = id_use_rs2 && (id_rs2 == id_ex_rd);
        return id_ex_valid && id_ex_mem_read && (id_ex_rd != 5'd0) && (rs1_match || rs2_match);
    endfunction

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface hazard_control_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       id_ex_rd;
    logic             id_ex_mem_read;
    logic             id_ex_valid;
    logic             ex_branch_taken;
    logic             mem_req;
    logic             mem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_write;
    logic             id_ex_flush;
    logic             ex_mem_write;
    logic             mem_wb_flush;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_mem_read,
               id_ex_valid, ex_branch_taken, mem_req, mem_ready,
        input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_flush, mem_timeout, stall_cycles, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, id_ex_rd, id_ex_mem_read,
               id_ex_valid, ex_branch_taken, mem_req, mem_ready,
        output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
               ex_mem_write, mem_wb_flush, mem_timeout, stall_cycles, flush_count
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline: memory-wait freeze, branch flush,
// load-use bubble, plus a wait-timeout monitor and saturating performance counters.
module hazard_control_unit
    import hazard_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  reset,
    hazard_control_unit_if.slave hz
);
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    hz_state_t         state_q;
    hz_state_t         state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              mem_timeout_q;
    logic              mem_timeout_d;

    logic              freeze;
    logic              load_use;
    logic              branch_flush;
    logic              stall_inc;
    hz_ctrl_t          ctrl;

    always_comb begin
        freeze = ((state_q == HZ_RUN) && hz.mem_req && !hz.mem_ready)
              || ((state_q == HZ_MEM_WAIT) && !hz.mem_ready);
        load_use = load_use_hit(hz.id_ex_valid, hz.id_ex_mem_read, hz.id_ex_rd,
                                hz.id_rs1, hz.id_rs2, hz.id_use_rs1, hz.id_use_rs2);
        branch_flush = !reset && !freeze && hz.ex_branch_taken;
    end

    // A branch seen during a freeze is dropped on purpose: EX is held, so it re-asserts on release.
    always_comb begin
        ctrl = CTRL_DEFAULT;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else if (freeze) begin
            ctrl = CTRL_FREEZE;
        end else if (hz.ex_branch_taken) begin
            ctrl = CTRL_FLUSH;
        end else if (load_use) begin
            ctrl = CTRL_STALL;
        end
    end

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        mem_timeout_d = mem_timeout_q;
        case (state_q)
            HZ_RUN: begin
                if (hz.mem_req && !hz.mem_ready) begin
                    state_d    = HZ_MEM_WAIT;
                    wait_cnt_d = '0;
                end
            end
            HZ_MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = HZ_RUN;
                end else begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                    if (wait_cnt_d == WAIT_MAX) begin
                        mem_timeout_d = 1'b1;
                    end
                end
            end
            default: state_d = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= HZ_RUN;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign stall_inc = !reset && !ctrl.pc_write;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_inc),
        .count (hz.stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (branch_flush),
        .count (hz.flush_count)
    );

    assign hz.pc_write     = ctrl.pc_write;
    assign hz.if_id_write  = ctrl.if_id_write;
    assign hz.if_id_flush  = ctrl.if_id_flush;
    assign hz.id_ex_write  = ctrl.id_ex_write;
    assign hz.id_ex_flush  = ctrl.id_ex_flush;
    assign hz.ex_mem_write = ctrl.ex_mem_write;
    assign hz.mem_wb_flush = ctrl.mem_wb_flush;
    assign hz.mem_timeout  = mem_timeout_q;
endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench: dut_a (CNT_W=16, MEM_TIMEOUT=3) and dut_b (CNT_W=2, MEM_TIMEOUT=255)
// see identical stimulus; control vectors are packed {pc,ifid_w,ifid_f,idex_w,idex_f,exmem_w,memwb_f}.
module tb_hazard_control_unit;

    localparam logic [6:0] C_NORMAL = 7'b1101010;
    localparam logic [6:0] C_RESET  = 7'b0010101;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_FLUSH  = 7'b1111110;
    localparam logic [6:0] C_STALL  = 7'b0001110;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, id_ex_rd;
    logic       id_use_rs1, id_use_rs2, id_ex_mem_read, id_ex_valid;
    logic       ex_branch_taken, mem_req, mem_ready;

    int checks   = 0;
    int failures = 0;

    hazard_control_unit_if #(.CNT_W(16)) bus_a ();
    hazard_control_unit_if #(.CNT_W(2))  bus_b ();

    assign bus_a.id_rs1 = id_rs1;             assign bus_b.id_rs1 = id_rs1;
    assign bus_a.id_rs2 = id_rs2;             assign bus_b.id_rs2 = id_rs2;
    assign bus_a.id_use_rs1 = id_use_rs1;     assign bus_b.id_use_rs1 = id_use_rs1;
    assign bus_a.id_use_rs2 = id_use_rs2;     assign bus_b.id_use_rs2 = id_use_rs2;
    assign bus_a.id_ex_rd = id_ex_rd;         assign bus_b.id_ex_rd = id_ex_rd;
    assign bus_a.id_ex_mem_read = id_ex_mem_read;
    assign bus_b.id_ex_mem_read = id_ex_mem_read;
    assign bus_a.id_ex_valid = id_ex_valid;   assign bus_b.id_ex_valid = id_ex_valid;
    assign bus_a.ex_branch_taken = ex_branch_taken;
    assign bus_b.ex_branch_taken = ex_branch_taken;
    assign bus_a.mem_req = mem_req;           assign bus_b.mem_req = mem_req;
    assign bus_a.mem_ready = mem_ready;       assign bus_b.mem_ready = mem_ready;

    hazard_control_unit #(.CNT_W(16), .MEM_TIMEOUT(3)) dut_a (
        .clk   (clk),
        .reset (reset),
        .hz    (bus_a)
    );

    hazard_control_unit #(.CNT_W(2), .MEM_TIMEOUT(255)) dut_b (
        .clk   (clk),
        .reset (reset),
        .hz    (bus_b)
    );

    wire [6:0] ctrl_a = {bus_a.pc_write, bus_a.if_id_write, bus_a.if_id_flush, bus_a.id_ex_write,
                         bus_a.id_ex_flush, bus_a.ex_mem_write, bus_a.mem_wb_flush};
    wire [6:0] ctrl_b = {bus_b.pc_write, bus_b.if_id_write, bus_b.if_id_flush, bus_b.id_ex_write,
                         bus_b.id_ex_flush, bus_b.ex_mem_write, bus_b.mem_wb_flush};

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(
        input logic       valid, input logic mem_rd, input logic [4:0] rd,
        input logic [4:0] rs1,   input logic [4:0] rs2,
        input logic       use1,  input logic use2,
        input logic       br,    input logic req,   input logic rdy
    );
        id_ex_valid     = valid;
        id_ex_mem_read  = mem_rd;
        id_ex_rd        = rd;
        id_rs1          = rs1;
        id_rs2          = rs2;
        id_use_rs1      = use1;
        id_use_rs2      = use2;
        ex_branch_taken = br;
        mem_req         = req;
        mem_ready       = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic loadUse(input logic br);
        applyStimulus(1, 1, 5'd5, 5'd9, 5'd5, 0, 1, br, 0, 0);
    endtask

    task automatic checkCounters(input string tag, input int sa, input int fa, input int sb);
        checkOutput({tag, "_stall_a"}, 32'(bus_a.stall_cycles), 32'(sa));
        checkOutput({tag, "_flush_a"}, 32'(bus_a.flush_count), 32'(fa));
        checkOutput({tag, "_stall_b"}, 32'(bus_b.stall_cycles), 32'(sb));
    endtask

    initial begin
        reset = 1'b1;
        idle();
        repeat (3) tick();
        checkOutput("reset_ctrl_a", 32'(ctrl_a), 32'(C_RESET));
        checkOutput("reset_ctrl_b", 32'(ctrl_b), 32'(C_RESET));
        checkOutput("reset_timeout_a", 32'(bus_a.mem_timeout), 32'd0);
        checkCounters("reset", 0, 0, 0);

        reset = 1'b0;
        idle();
        checkOutput("idle_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        tick();
        checkCounters("idle", 0, 0, 0);

        loadUse(0);
        checkOutput("lu_rs2_ctrl", 32'(ctrl_a), 32'(C_STALL));
        tick();
        checkCounters("lu_rs2", 1, 0, 1);
        idle();
        checkOutput("lu_advanced_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        tick();
        checkCounters("lu_advanced", 1, 0, 1);

        applyStimulus(1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0);
        checkOutput("lu_rd0_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        tick();
        applyStimulus(1, 1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, 0);
        checkOutput("lu_rs1_ctrl", 32'(ctrl_b), 32'(C_STALL));
        tick();
        checkCounters("lu_rs1", 2, 0, 2);
        applyStimulus(1, 1, 5'd7, 5'd7, 5'd7, 0, 0, 0, 0, 0);
        checkOutput("lu_unused_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        applyStimulus(0, 1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, 0);
        checkOutput("lu_bubble_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        applyStimulus(1, 0, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, 0);
        checkOutput("lu_notload_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        tick();
        checkCounters("lu_neg", 2, 0, 2);

        loadUse(1);
        checkOutput("br_over_lu_ctrl", 32'(ctrl_a), 32'(C_FLUSH));
        tick();
        checkCounters("br_over_lu", 2, 1, 2);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, (i >= 2), 1, 0);
            checkOutput($sformatf("wait%0d_ctrl", i), 32'(ctrl_a), 32'(C_FREEZE));
            tick();
            checkOutput($sformatf("wait%0d_timeout_a", i), 32'(bus_a.mem_timeout), 32'(i == 3));
        end
        checkCounters("wait4", 6, 1, 3);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1);
        checkOutput("release_br_ctrl", 32'(ctrl_a), 32'(C_FLUSH));
        tick();
        checkCounters("release", 6, 2, 3);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        checkOutput("back_in_run_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
        checkOutput("req_ready_same_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        tick();
        checkOutput("sticky_timeout_a", 32'(bus_a.mem_timeout), 32'd1);
        checkOutput("no_timeout_b", 32'(bus_b.mem_timeout), 32'd0);

        reset = 1'b1;
        idle();
        tick();
        checkOutput("reset2_timeout_a", 32'(bus_a.mem_timeout), 32'd0);
        checkCounters("reset2", 0, 0, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0);
            tick();
            checkOutput($sformatf("to%0d_timeout_a", i), 32'(bus_a.mem_timeout), 32'(i >= 3));
        end
        checkCounters("to6", 6, 0, 3);
        applyStimulus(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1);
        checkOutput("to_release_ctrl", 32'(ctrl_a), 32'(C_NORMAL));
        tick();
        checkOutput("to_sticky_a", 32'(bus_a.mem_timeout), 32'd1);
        checkOutput("to_none_b", 32'(bus_b.mem_timeout), 32'd0);

        reset = 1'b1;
        idle();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            loadUse(0);
            tick();
            checkOutput($sformatf("sat%0d_stall_b", i), 32'(bus_b.stall_cycles), 32'((i >= 2) ? 3 : i + 1));
            idle();
            tick();
        end
        checkCounters("sat", 5, 0, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
